// File: rtl/knn_sort_pkg.sv
// Shared defaults, FSM encoding and constants for the KNN top-K sorter.
// Imported by the insert-position and list/FSM modules.
package knn_sort_pkg;

  localparam int KNN_K       = 4;
  localparam int KNN_DIST_W  = 32;
  localparam int KNN_LABEL_W = 8;

  localparam logic [KNN_DIST_W-1:0] KNN_DIST_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } knn_state_e;

endpackage

// File: rtl/knn_insert_pos.sv
// Insertion position for a new distance: count of valid entries
// whose distance is <= the new one, so ties land behind existing entries.
module knn_insert_pos
  import knn_sort_pkg::*;
#(
  parameter int K      = KNN_K,
  parameter int DIST_W = KNN_DIST_W,
  parameter int CNT_W  = $clog2(K + 1)
) (
  input  logic [K-1:0][DIST_W-1:0] dist_i,
  input  logic [K-1:0]             valid_i,
  input  logic [DIST_W-1:0]        new_dist_i,
  output logic [CNT_W-1:0]         pos_o
);

  logic [K-1:0] hit;

  always_comb begin
    hit   = '0;
    pos_o = '0;
    for (int i = 0; i < K; i++) begin
      hit[i] = valid_i[i] & (dist_i[i] <= new_dist_i);
      pos_o  = pos_o + CNT_W'(hit[i]);
    end
  end

endmodule

// File: rtl/knn_sort.sv
// Streaming top-K selector: stage-1 capture, stage-2 parallel compare
// and shift-insert into an ascending register list with an indexed read port.
module knn_sort
  import knn_sort_pkg::*;
#(
  parameter int K       = KNN_K,
  parameter int DIST_W  = KNN_DIST_W,
  parameter int LABEL_W = KNN_LABEL_W,
  parameter int IDX_W   = $clog2(K),
  parameter int CNT_W   = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIST_W-1:0]  in_dist,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               done,
  output logic [CNT_W-1:0]   nn_count,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [DIST_W-1:0]  rd_dist,
  output logic [LABEL_W-1:0] rd_label,
  output logic               rd_valid
);

  knn_state_e state_q, state_d;

  logic [K-1:0][DIST_W-1:0]  dist_q, dist_d;
  logic [K-1:0][LABEL_W-1:0] label_q, label_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic               s1_valid_q, s1_valid_d;
  logic [DIST_W-1:0]  s1_dist_q, s1_dist_d;
  logic [LABEL_W-1:0] s1_label_q, s1_label_d;

  logic [K-1:0]     ent_valid;
  logic [CNT_W-1:0] pos;
  logic             accept;

  assign in_ready = (state_q == ST_RUN) & ~start;
  assign accept   = in_valid & in_ready;
  assign done     = (state_q == ST_DONE);
  assign nn_count = cnt_q;

  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < K; i++) begin
      ent_valid[i] = CNT_W'(i) < cnt_q;
    end
  end

  knn_insert_pos #(
    .K      (K),
    .DIST_W (DIST_W),
    .CNT_W  (CNT_W)
  ) u_pos (
    .dist_i     (dist_q),
    .valid_i    (ent_valid),
    .new_dist_i (s1_dist_q),
    .pos_o      (pos)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s1_valid_d = accept;
    s1_dist_d  = s1_dist_q;
    s1_label_d = s1_label_q;
    if (accept) begin
      s1_dist_d  = in_dist;
      s1_label_d = in_label;
    end
  end

  // start discards whatever sits in stage 1 along with the list
  always_comb begin
    dist_d  = dist_q;
    label_d = label_q;
    cnt_d   = cnt_q;
    if (start) begin
      dist_d  = '1;
      label_d = '0;
      cnt_d   = '0;
    end else if (s1_valid_q && pos < CNT_W'(K)) begin
      for (int i = 1; i < K; i++) begin
        if (CNT_W'(i) > pos) begin
          dist_d[i]  = dist_q[i-1];
          label_d[i] = label_q[i-1];
        end
      end
      for (int i = 0; i < K; i++) begin
        if (CNT_W'(i) == pos) begin
          dist_d[i]  = s1_dist_q;
          label_d[i] = s1_label_q;
        end
      end
      if (cnt_q != CNT_W'(K)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_valid = CNT_W'(rd_idx) < cnt_q;
    rd_dist  = '1;
    rd_label = '0;
    if (CNT_W'(rd_idx) < CNT_W'(K)) begin
      rd_dist  = dist_q[rd_idx];
      rd_label = label_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dist_q     <= '1;
      label_q    <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_dist_q  <= '0;
      s1_label_q <= '0;
    end else begin
      state_q    <= state_d;
      dist_q     <= dist_d;
      label_q    <= label_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_dist_q  <= s1_dist_d;
      s1_label_q <= s1_label_d;
    end
  end

endmodule

// File: tb/tb_knn_sort.sv
// Scoreboard bench for knn_sort: stimulus queues expected list entries,
// a negedge monitor drives rd_idx and compares the read port.
module tb_knn_sort;
  import knn_sort_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dist;
  logic [7:0]  in_label;
  logic        in_last;
  logic        done;
  logic [2:0]  nn_count;
  logic [1:0]  rd_idx;
  logic [31:0] rd_dist;
  logic [7:0]  rd_label;
  logic        rd_valid;

  knn_sort dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dist  (in_dist),
    .in_label (in_label),
    .in_last  (in_last),
    .done     (done),
    .nn_count (nn_count),
    .rd_idx   (rd_idx),
    .rd_dist  (rd_dist),
    .rd_label (rd_label),
    .rd_valid (rd_valid)
  );

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic [7:0]  l;
    logic        v;
    logic [2:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] d,
                      input logic [7:0] l, input logic v,
                      input logic [2:0] c);
    exp_t e;
    e.idx = idx; e.d = d; e.l = l; e.v = v; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_empty(input int from, input logic [2:0] c);
    for (int i = from; i < 4; i++) push(i, KNN_DIST_ONES, 8'h0, 1'b0, c);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] l,
                      input logic last);
    in_valid = 1'b1;
    in_dist  = d;
    in_label = l;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: one queued expectation per negedge, read port settled #1 later
  initial begin
    exp_t e;
    rd_idx = '0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        rd_idx = 2'(e.idx);
        #1;
        chk($sformatf("rd_dist[%0d]", e.idx), 64'(rd_dist), 64'(e.d));
        chk($sformatf("rd_label[%0d]", e.idx), 64'(rd_label), 64'(e.l));
        chk($sformatf("rd_valid[%0d]", e.idx), 64'(rd_valid), 64'(e.v));
        chk($sformatf("nn_count@%0d", e.idx), 64'(nn_count), 64'(e.c));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_dist  = '0;
    in_label = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset / idle
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    push_empty(0, 3'd0);
    wait_drain();

    // basic stream, last on 30
    do_start();
    send(32'd50, 8'd1, 1'b0);
    send(32'd20, 8'd2, 1'b0);
    send(32'd80, 8'd3, 1'b0);
    send(32'd10, 8'd4, 1'b0);
    send(32'd30, 8'd5, 1'b1);
    chk("drain_done", 64'(done), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("done_rise", 64'(done), 64'd1);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    push(0, 32'd10, 8'd4, 1'b1, 3'd4);
    push(1, 32'd20, 8'd2, 1'b1, 3'd4);
    push(2, 32'd30, 8'd5, 1'b1, 3'd4);
    push(3, 32'd50, 8'd1, 1'b1, 3'd4);
    wait_drain();

    // ties keep arrival order
    do_start();
    chk("start_clears_done", 64'(done), 64'd0);
    send(32'd7, 8'hA, 1'b0);
    send(32'd7, 8'hB, 1'b0);
    send(32'd7, 8'hC, 1'b1);
    wait_done();
    push(0, 32'd7, 8'hA, 1'b1, 3'd3);
    push(1, 32'd7, 8'hB, 1'b1, 3'd3);
    push(2, 32'd7, 8'hC, 1'b1, 3'd3);
    push_empty(3, 3'd3);
    wait_drain();

    // tie against a full list is discarded
    do_start();
    send(32'd5, 8'd1, 1'b0);
    send(32'd5, 8'd2, 1'b0);
    send(32'd5, 8'd3, 1'b0);
    send(32'd5, 8'd4, 1'b0);
    send(32'd5, 8'hD, 1'b1);
    wait_done();
    push(0, 32'd5, 8'd1, 1'b1, 3'd4);
    push(1, 32'd5, 8'd2, 1'b1, 3'd4);
    push(2, 32'd5, 8'd3, 1'b1, 3'd4);
    push(3, 32'd5, 8'd4, 1'b1, 3'd4);
    wait_drain();

    // larger than all in a full list
    do_start();
    send(32'd1, 8'd1, 1'b0);
    send(32'd2, 8'd2, 1'b0);
    send(32'd3, 8'd3, 1'b0);
    send(32'd4, 8'd4, 1'b0);
    send(32'd100, 8'd9, 1'b1);
    wait_done();
    push(0, 32'd1, 8'd1, 1'b1, 3'd4);
    push(1, 32'd2, 8'd2, 1'b1, 3'd4);
    push(2, 32'd3, 8'd3, 1'b1, 3'd4);
    push(3, 32'd4, 8'd4, 1'b1, 3'd4);
    wait_drain();

    // start mid-query beats a same-cycle sample
    do_start();
    send(32'd40, 8'd1, 1'b0);
    send(32'd60, 8'd2, 1'b0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_dist  = 32'd5;
    in_label = 8'd9;
    #1 chk("start_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    push_empty(0, 3'd0);
    wait_drain();
    send(32'd25, 8'd7, 1'b0);
    send(32'd15, 8'd8, 1'b1);
    wait_done();
    push(0, 32'd15, 8'd8, 1'b1, 3'd2);
    push(1, 32'd25, 8'd7, 1'b1, 3'd2);
    push_empty(2, 3'd2);
    wait_drain();

    // reset between back-to-back samples
    do_start();
    send(32'd3, 8'd1, 1'b0);
    send(32'd6, 8'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mid_count", 64'(nn_count), 64'd0);
    push_empty(0, 3'd0);
    wait_drain();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", 64'(in_ready), 64'd0);
    do_start();
    send(32'd9, 8'd3, 1'b1);
    wait_done();
    push(0, 32'd9, 8'd3, 1'b1, 3'd1);
    push_empty(1, 3'd1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
